// File: rtl/arith_pkg.sv
// Shared constants for the mux-based arithmetic cells: FSM encodings and
// 8:1-mux truth tables (bit i is the cell output for select value i).
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sub_state_e;

   // Full-subtractor tables, select = {a, b, borrow_in}
   localparam logic [7:0] FS_DIFF_TT  = 8'b1001_0110;
   localparam logic [7:0] FS_BRW_TT   = 8'b1000_1110;

   // Full-adder tables, select = {a, b, carry_in}
   localparam logic [7:0] FA_SUM_TT   = 8'b1001_0110;
   localparam logic [7:0] FA_CARRY_TT = 8'b1110_1000;

endpackage

// File: rtl/fs_cell_mux8.sv
// Combinational full-subtractor cell: two 8:1 muxes whose data inputs are the
// difference and borrow truth tables, selected by {a, b, bi}.
module fs_cell_mux8
   import arith_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   logic [2:0] sel;
   logic [1:0] mux_out;

   assign sel = {a, b, bi};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_mux
         // Mux 0 produces the difference bit, mux 1 the borrow-out.
         localparam logic [7:0] TT = (gi == 0) ? FS_DIFF_TT : FS_BRW_TT;
         logic y;

         always_comb begin
            y = 1'b0;
            unique case (sel)
               3'd0: y = TT[0];
               3'd1: y = TT[1];
               3'd2: y = TT[2];
               3'd3: y = TT[3];
               3'd4: y = TT[4];
               3'd5: y = TT[5];
               3'd6: y = TT[6];
               3'd7: y = TT[7];
            endcase
         end

         assign mux_out[gi] = y;
      end
   endgenerate

   assign d  = mux_out[0];
   assign bo = mux_out[1];

endmodule

// File: rtl/serial_full_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock through a single
// mux-based full-subtractor cell; the borrow is carried in a flip-flop.
module serial_full_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   sub_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_sr_q, res_sr_d;
   logic             brw_q, brw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   logic             d_bit;
   logic             b_bit;
   logic [WIDTH-1:0] res_shift;
   logic             last_bit;

   fs_cell_mux8 u_cell (
      .a  (a_sr_q[0]),
      .b  (b_sr_q[0]),
      .bi (brw_q),
      .d  (d_bit),
      .bo (b_bit)
   );

   // New difference bit enters at the MSB so the LSB-first result lines up
   // after WIDTH shifts.
   generate
      if (WIDTH > 1) begin : g_shift_wide
         assign res_shift = {d_bit, res_sr_q[WIDTH-1:1]};
      end else begin : g_shift_one
         assign res_shift = d_bit;
      end
   endgenerate

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_sr_d = res_sr_q;
      brw_d    = brw_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bout_d   = bout_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               brw_d   = bin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            brw_d    = b_bit;
            res_sr_d = res_shift;
            cnt_d    = cnt_q + CW'(1);
            // Publish on the final step so the result is already visible
            // during the DONE cycle.
            if (last_bit) begin
               diff_d  = res_shift;
               bout_d  = b_bit;
               state_d = ST_DONE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         brw_q    <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_sr_q <= res_sr_d;
         brw_q    <= brw_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed bench for the bit-serial subtractor: an 8-bit instance for the
// vector table and corner sequences, a 2-bit instance for an exhaustive sweep.
module tb_serial_full_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       bin8 = 1'b0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   logic       start2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       bin2 = 1'b0;
   logic       busy2, done2, bout2;
   logic [1:0] diff2;

   int checks = 0;
   int failures = 0;

   serial_full_subtractor #(.WIDTH(8), .CW(6)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_full_subtractor #(.WIDTH(2), .CW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
      .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts an 8-bit operation (from IDLE or DONE) and returns in its DONE cycle.
   task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic bi, input logic [7:0] ed, input logic eb);
      int lat, busy_n, hold_bad;
      logic [7:0] snap;
      a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      snap = diff8;
      lat = 0; busy_n = 0; hold_bad = 0;
      while (!done8 && lat < 20) begin
         if (busy8) busy_n++;
         if (diff8 !== snap) hold_bad++;
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, 8);
      check({tag, " busy cycles"}, busy_n, 8);
      check({tag, " diff held in RUN"}, hold_bad, 0);
      check({tag, " diff"}, diff8, ed);
      check({tag, " bout"}, bout8, eb);
      check({tag, " busy in DONE"}, busy8, 0);
      $display("op8 %s a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d lat=%0d",
               tag, av, bv, bi, diff8, bout8, lat);
   endtask

   task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic bi);
      int lat, model;
      model = int'(av) - int'(bv) - int'(bi);
      a2 = av; b2 = bv; bin2 = bi; start2 = 1'b1;
      tick();
      start2 = 1'b0;
      lat = 0;
      while (!done2 && lat < 10) begin
         tick();
         lat++;
      end
      check("w2 done spacing", lat, 2);
      check("w2 diff", diff2, model & 3);
      check("w2 bout", bout2, (model < 0) ? 1 : 0);
      $display("op2 a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d lat=%0d",
               av, bv, bi, diff2, bout2, lat);
   endtask

   initial begin
      int lat, pulses;

      vecs[0] = '{8'd200, 8'd55,  1'b0, 8'd145, 1'b0};
      vecs[1] = '{8'd5,   8'd10,  1'b0, 8'd251, 1'b1};
      vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
      vecs[3] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
      vecs[4] = '{8'd128, 8'd1,   1'b1, 8'd126, 1'b0};
      vecs[5] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1};

      repeat (3) @(posedge clk);
      #1;
      check("reset busy", busy8, 0);
      check("reset done", done8, 0);
      check("reset diff", diff8, 0);
      check("reset bout", bout8, 0);
      check("reset w2 diff", diff2, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo);
      end

      // start re-asserted with other operands while busy must be ignored
      a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
      repeat (4) tick();
      start8 = 1'b0;
      lat = 5;
      while (!done8 && lat < 20) begin
         tick();
         lat++;
      end
      check("ignore latency", lat, 8);
      check("ignore diff", diff8, 145);
      check("ignore bout", bout8, 0);
      $display("ignore-start a=200 b=55 -> diff=%0d bout=%0d lat=%0d", diff8, bout8, lat);

      // back-to-back: start in the DONE cycle, 145 must be held through RUN
      op8("b2b", 8'd9, 8'd3, 1'b0, 8'd6, 1'b0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8) pulses++;
      end
      check("no extra done", pulses, 0);

      op8("pre-reset", 8'd3, 8'd4, 1'b0, 8'd255, 1'b1);

      // asynchronous reset in the middle of RUN
      a8 = 8'd100; b8 = 8'd30; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      check("async rst busy", busy8, 0);
      check("async rst done", done8, 0);
      check("async rst diff", diff8, 0);
      check("async rst bout", bout8, 0);
      $display("reset mid-RUN -> busy=%0d done=%0d diff=%0d bout=%0d", busy8, done8, diff8, bout8);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8 || busy8) pulses++;
      end
      check("aborted op silent", pulses, 0);
      op8("post-reset", 8'd100, 8'd30, 1'b0, 8'd70, 1'b0);

      // exhaustive 2-bit sweep, issued back-to-back
      for (int ai = 0; ai < 4; ai++) begin
         for (int bi = 0; bi < 4; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               op2(2'(ai), 2'(bi), 1'(ci));
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_full_subtractor.md
Name: serial_full_subtractor

Overview:
- Bit-serial N-bit subtractor computing A - B - Bin, LSB first, one bit per clock.
- Per-bit difference and borrow come from an 8:1-mux truth-table full-subtractor cell, select = {a_bit, b_bit, borrow}.
- Borrow is held in a flip-flop between bit steps.
- Serves as the subtract path that complements the team's mux-based full-adder datapath blocks, trading area for WIDTH cycles of latency.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).
- CW, 6, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      begin an operation; sampled in IDLE or DONE only
- a      input   WIDTH  minuend; captured on accepted start
- b      input   WIDTH  subtrahend; captured on accepted start
- bin    input   1      borrow-in; captured on accepted start
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse, result valid
- diff   output  WIDTH  difference; held stable from done until next accepted start
- bout   output  1      final borrow-out; held like diff

Behaviour:
- Reset: asynchronous on rst_n low; everything returns to zero.
  - state = IDLE; busy = 0, done = 0, diff = 0, bout = 0.
  - Shift registers, borrow FF and counter all cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, load a_sr<=a, b_sr<=b, brw<=bin, cnt<=0, go to RUN. Otherwise stay.
  - RUN: busy=1. Each cycle the cell sees s = {a_sr[0], b_sr[0], brw}.
    - d_bit = mux8(s) with inputs i7..i0 = 1,0,0,1,0,1,1,0.
    - b_bit = mux8(s) with inputs i7..i0 = 1,0,0,0,1,1,1,0.
    - a_sr and b_sr shift right by 1; brw <= b_bit.
    - res_sr shifts right with d_bit entering at bit WIDTH-1; cnt++.
    - When cnt == WIDTH-1 (the last bit processed), go to DONE.
  - DONE (exactly one cycle): done=1, busy=0; diff <= res_sr, bout <= brw. The outputs are registered and visible in the DONE cycle.
    - start=1 in DONE is accepted exactly as in IDLE (next state RUN, back-to-back).
    - Otherwise go to IDLE.
- Latency: start sampled high at edge k → busy high from cycle k+1 for WIDTH cycles → done high in cycle k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while busy is ignored; operands are not re-sampled; the in-flight operation is unaffected.
- diff/bout are not updated during RUN; they keep the previous result until the next DONE.
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH. bout = 1 iff a < b + bin, treated as unsigned.
- Reset mid-RUN aborts the operation; no done pulse is produced; outputs are zeroed.
- WIDTH=1: RUN lasts one cycle; the same rules apply.

Decomposition:
- Shared package/include `arith_pkg`:
  - FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Truth-table constants FS_DIFF_TT=8'b1001_0110 and FS_BRW_TT=8'b1000_1110 (bit i = output for select i). The same package holds the adder constants FA_SUM_TT and FA_CARRY_TT.
- One sub-module: `fs_cell_mux8`, a combinational 8:1-mux full-subtractor cell (inputs a, b, bi; outputs d, bo). It is built from two 8:1 muxes fed by the table constants and is instantiated once.
- FSM, shift registers and counter live in the top module.

Test Plan:
- WIDTH=8, a=200, b=55, bin=0, start pulse at cycle 0 → busy cycles 1-8, done at cycle 9, diff=145 (8'h91), bout=0.
- a=5, b=10, bin=0 → diff=251 (8'hFB), bout=1. Then a=0, b=0, bin=1 → diff=255, bout=1.
- Exhaustive WIDTH=2 sweep (a, b 0..3, bin 0..1, 32 cases) → diff and bout match the reference model; done spacing is exactly 3 cycles.
- start re-asserted with a=1, b=1 in cycles 2-5 during a 200-55 operation → result is still 145; no extra done pulse.
- Back-to-back: start high in the DONE cycle with a=9, b=3 → next done 9 cycles later with diff=6. The previous diff=145 is held through RUN.
- rst_n low at cycle 4 of RUN for 2 cycles → all outputs 0 immediately (asynchronous), state IDLE, no done pulse. A new start after release completes normally.
